// File: rtl/traffic_light_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl
//
// Phase sequencer for a two-road intersection (main road / side road).
// Counts one-second ticks per phase and drives the red/yellow/green lamps of
// both roads. Main green is held until the side-road sensor asks for service;
// night mode parks the junction in a flashing-yellow state.
//
// Phase order (timed):
//   MAIN_G -> MAIN_Y -> RED_A -> SIDE_G -> SIDE_Y -> RED_B -> MAIN_G
// Either all-red phase diverts to NIGHT when night_mode is set; NIGHT leaves
// through RED_B once night_mode drops.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset, sampled on rising clk
//   a_second    one-clk tick, once per second (every high cycle counts)
//   side_req    side-road vehicle sensor, level or pulse
//   night_mode  request flashing-yellow operation
//   main_light  {red,yellow,green} for the main road
//   side_light  {red,yellow,green} for the side road
//   phase       current state encoding
//   sec_left    ticks remaining in the current phase (0 in NIGHT)
//
// All outputs are decoded from registered state only; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter int GREEN_TIME   = 20,  // 1..63
  parameter int YELLOW_TIME  = 5,   // 1..63
  parameter int ALL_RED_TIME = 2    // 1..63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_second,
  input  logic       side_req,
  input  logic       night_mode,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase,
  output logic [5:0] sec_left
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5,
    NIGHT  = 3'd6,
    ILLEGAL = 3'd7
  } state_e;

  // Last count value of each timed phase (D-1).
  localparam logic [5:0] GREEN_LAST   = 6'(GREEN_TIME - 1);
  localparam logic [5:0] YELLOW_LAST  = 6'(YELLOW_TIME - 1);
  localparam logic [5:0] ALL_RED_LAST = 6'(ALL_RED_TIME - 1);

  // Lamp patterns {red,yellow,green}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       req_lat_q, req_lat_d;
  logic       blink_q, blink_d;

  logic [5:0] last_cnt;   // D-1 of the current phase
  logic       at_last;    // counter sits on the final tick slot

  // Phase duration lookup; untimed states report 0 so sec_left reads 0.
  always_comb begin
    last_cnt = 6'd0;
    case (state_q)
      MAIN_G, SIDE_G: last_cnt = GREEN_LAST;
      MAIN_Y, SIDE_Y: last_cnt = YELLOW_LAST;
      RED_A, RED_B:   last_cnt = ALL_RED_LAST;
      default:        last_cnt = 6'd0;
    endcase
  end

  assign at_last = (cnt_q == last_cnt);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RED_B;
      cnt_q     <= 6'd0;
      req_lat_q <= 1'b0;
      blink_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_lat_q <= req_lat_d;
      blink_q   <= blink_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_lat_d = req_lat_q;
    blink_d   = blink_q;

    // Side requests only matter while the side road is not already green.
    if (side_req && (state_q != SIDE_G)) begin
      req_lat_d = 1'b1;
    end

    if (state_q == ILLEGAL) begin
      // Unused encoding: park in all-red without waiting for a tick.
      state_d = RED_B;
      cnt_d   = 6'd0;
    end else if (a_second) begin
      case (state_q)
        MAIN_G: begin
          if (!at_last) begin
            cnt_d = cnt_q + 6'd1;
          end else if (req_lat_q || night_mode) begin
            state_d = MAIN_Y;
            cnt_d   = 6'd0;
          end
          // else: green is held with the counter parked on its last slot
        end
        MAIN_Y: begin
          if (at_last) begin
            state_d = RED_A;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        RED_A: begin
          if (at_last) begin
            state_d = night_mode ? NIGHT : SIDE_G;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        SIDE_G: begin
          if (at_last) begin
            state_d = SIDE_Y;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        SIDE_Y: begin
          if (at_last) begin
            state_d = RED_B;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        RED_B: begin
          if (at_last) begin
            state_d = night_mode ? NIGHT : MAIN_G;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        NIGHT: begin
          if (!night_mode) begin
            state_d = RED_B;
            cnt_d   = 6'd0;
          end else begin
            blink_d = ~blink_q;
          end
        end
        default: begin
          state_d = RED_B;
          cnt_d   = 6'd0;
        end
      endcase
    end

    // Entering side green serves the pending request; this wins over a
    // request arriving on the same clock.
    if ((state_d == SIDE_G) && (state_q != SIDE_G)) begin
      req_lat_d = 1'b0;
    end

    // Flashing always starts with the lamps lit.
    if ((state_d == NIGHT) && (state_q != NIGHT)) begin
      blink_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    phase      = state_q;
    sec_left   = 6'd0;

    case (state_q)
      MAIN_G: begin
        main_light = LAMP_GREEN;
        side_light = LAMP_RED;
      end
      MAIN_Y: begin
        main_light = LAMP_YELLOW;
        side_light = LAMP_RED;
      end
      SIDE_G: begin
        main_light = LAMP_RED;
        side_light = LAMP_GREEN;
      end
      SIDE_Y: begin
        main_light = LAMP_RED;
        side_light = LAMP_YELLOW;
      end
      NIGHT: begin
        main_light = {1'b0, blink_q, 1'b0};
        side_light = {1'b0, blink_q, 1'b0};
      end
      default: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
      end
    endcase

    if ((state_q != NIGHT) && (state_q != ILLEGAL)) begin
      sec_left = last_cnt - cnt_q;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_second;
  logic       side_req;
  logic       night_mode;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [2:0] phase;
  logic [5:0] sec_left;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .GREEN_TIME  (20),
    .YELLOW_TIME (5),
    .ALL_RED_TIME(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_second  (a_second),
    .side_req  (side_req),
    .night_mode(night_mode),
    .main_light(main_light),
    .side_light(side_light),
    .phase     (phase),
    .sec_left  (sec_left)
  );

  // Stimulus/expectation record
  typedef struct {
    int         ticks;
    int         gap;
    logic       side_lvl;
    logic       night;
    logic       pulse;
    logic [2:0] ph;
    logic [5:0] sec;
    logic [2:0] ml;
    logic [2:0] sl;
  } vec_t;

  typedef struct {
    int         id;
    logic [2:0] ph;
    logic [5:0] sec;
    logic [2:0] ml;
    logic [2:0] sl;
  } exp_t;

  vec_t vecs[40];
  int   nvec = 0;
  exp_t sb_q[$];

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, OFF = 3'b000;

  function automatic void add(int ticks, logic side_lvl, logic night, logic pulse,
                              logic [2:0] ph, logic [5:0] sec, logic [2:0] ml, logic [2:0] sl);
    vecs[nvec].ticks    = ticks;
    vecs[nvec].gap      = 2;
    vecs[nvec].side_lvl = side_lvl;
    vecs[nvec].night    = night;
    vecs[nvec].pulse    = pulse;
    vecs[nvec].ph       = ph;
    vecs[nvec].sec      = sec;
    vecs[nvec].ml       = ml;
    vecs[nvec].sl       = sl;
    nvec++;
  endfunction

  // Lamp pair for a timed phase, straight from the lamp table.
  function automatic logic [5:0] lamps(logic [2:0] ph);
    case (ph)
      3'd0:    return {G, R};
      3'd1:    return {Y, R};
      3'd3:    return {R, G};
      3'd4:    return {R, Y};
      default: return {R, R};
    endcase
  endfunction

  // Expected phase/sec_left k ticks after leaving a held MAIN_G with a
  // request pending (side_req held high throughout).
  function automatic void cycle_model(int k, output logic [2:0] ph, output logic [5:0] sec);
    int dur[6];
    int phs[6];
    int o;
    dur = '{5, 2, 20, 5, 2, 20};
    phs = '{1, 2, 3, 4, 5, 0};
    ph  = 3'd0;
    sec = 6'd0;
    if (k > 0) begin
      o = (k - 1) % 54;
      for (int s = 0; s < 6; s++) begin
        if (o < dur[s]) begin
          ph  = 3'(phs[s]);
          sec = 6'(dur[s] - 1 - o);
          break;
        end
        o -= dur[s];
      end
    end
  endfunction

  task automatic push_exp(int id, logic [2:0] ph, logic [5:0] sec, logic [2:0] ml, logic [2:0] sl);
    exp_t e;
    e.id = id; e.ph = ph; e.sec = sec; e.ml = ml; e.sl = sl;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=0 entries want>=1");
      return;
    end
    e = sb_q.pop_front();
    if (phase !== e.ph) begin
      bad++;
      $display("FAIL id%0d phase got=%0d want=%0d", e.id, phase, e.ph);
    end
    total++;
    if (sec_left !== e.sec) begin
      bad++;
      $display("FAIL id%0d sec_left got=%0d want=%0d", e.id, sec_left, e.sec);
    end
    total++;
    if (main_light !== e.ml) begin
      bad++;
      $display("FAIL id%0d main_light got=%b want=%b", e.id, main_light, e.ml);
    end
    total++;
    if (side_light !== e.sl) begin
      bad++;
      $display("FAIL id%0d side_light got=%b want=%b", e.id, side_light, e.sl);
    end
    $display("id%0d phase=%0d sec_left=%0d main=%b side=%b", e.id, phase, sec_left, main_light, side_light);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One tick consumed on the next rising edge, followed by gap quiet clocks.
  task automatic tick(int gap);
    a_second = 1'b1;
    @(posedge clk); #1;
    a_second = 1'b0;
    idle(gap);
  endtask

  task automatic pulse_side(logic lvl);
    side_req = 1'b1;
    idle(1);
    side_req = lvl;
    idle(1);
  endtask

  // Two roads must never both show a non-red lamp outside NIGHT.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && phase !== 3'd6) begin
      total++;
      if (main_light !== R && side_light !== R) begin
        bad++;
        $display("FAIL safety main=%b side=%b want one road red", main_light, side_light);
      end
    end
  end

  task automatic run_cycle(int id, int gap);
    logic [2:0] ph;
    logic [5:0] sec;
    logic [5:0] lp;
    for (int k = 1; k <= 55; k++) begin
      cycle_model(k, ph, sec);
      lp = lamps(ph);
      push_exp(id, ph, sec, lp[5:3], lp[2:0]);
      tick(0);
      check_out();
      if (gap > 0) begin
        push_exp(id + 1, ph, sec, lp[5:3], lp[2:0]);
        idle(gap);
        check_out();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; a_second = 1'b0; side_req = 1'b0; night_mode = 1'b0;

    // ticks side night pulse | phase sec main side
    add(0,  0, 0, 0, 3'd5, 6'd1,  R, R);   // 0 reset state
    add(1,  0, 0, 0, 3'd5, 6'd0,  R, R);   // 1
    add(1,  0, 0, 0, 3'd0, 6'd19, G, R);   // 2 main green
    add(19, 0, 0, 0, 3'd0, 6'd0,  G, R);   // 3
    add(1,  0, 0, 0, 3'd0, 6'd0,  G, R);   // 4 held
    add(5,  0, 0, 0, 3'd0, 6'd0,  G, R);   // 5 still held
    add(1,  0, 0, 1, 3'd1, 6'd4,  Y, R);   // 6 pulse -> main yellow
    add(4,  0, 0, 0, 3'd1, 6'd0,  Y, R);   // 7
    add(1,  0, 0, 0, 3'd2, 6'd1,  R, R);   // 8 red A
    add(2,  0, 0, 0, 3'd3, 6'd19, R, G);   // 9 side green
    add(10, 0, 0, 1, 3'd3, 6'd9,  R, G);   // 10 request during SIDE_G ignored
    add(10, 0, 0, 0, 3'd4, 6'd4,  R, Y);   // 11 side yellow
    add(5,  0, 0, 0, 3'd5, 6'd1,  R, R);   // 12 red B
    add(2,  0, 0, 0, 3'd0, 6'd19, G, R);   // 13
    add(25, 0, 0, 0, 3'd0, 6'd0,  G, R);   // 14 held: latch was cleared
    add(1,  1, 0, 0, 3'd1, 6'd4,  Y, R);   // 15 level request
    add(54, 1, 0, 0, 3'd1, 6'd4,  Y, R);   // 16 54-tick period
    add(17, 1, 0, 0, 3'd3, 6'd9,  R, G);   // 17
    add(37, 1, 0, 0, 3'd1, 6'd4,  Y, R);   // 18 not extended by SIDE_G req
    add(34, 0, 0, 0, 3'd0, 6'd19, G, R);   // 19
    add(20, 0, 0, 0, 3'd0, 6'd0,  G, R);   // 20 held
    add(1,  0, 1, 0, 3'd1, 6'd4,  Y, R);   // 21 night from held green
    add(5,  0, 1, 0, 3'd2, 6'd1,  R, R);   // 22
    add(2,  0, 1, 0, 3'd6, 6'd0,  Y, Y);   // 23 night starts lit
    add(1,  0, 1, 0, 3'd6, 6'd0,  OFF, OFF); // 24
    add(1,  0, 1, 0, 3'd6, 6'd0,  Y, Y);   // 25
    add(3,  0, 1, 0, 3'd6, 6'd0,  OFF, OFF); // 26
    add(1,  0, 0, 0, 3'd5, 6'd1,  R, R);   // 27 leave night
    add(2,  0, 0, 0, 3'd0, 6'd19, G, R);   // 28
    add(50, 0, 0, 1, 3'd4, 6'd1,  R, Y);   // 29 SIDE_Y with cnt=3

    idle(2);
    rst_n = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      side_req   = vecs[i].side_lvl;
      night_mode = vecs[i].night;
      push_exp(i, vecs[i].ph, vecs[i].sec, vecs[i].ml, vecs[i].sl);
      if (vecs[i].ticks > 0) begin
        idle(1);
        if (vecs[i].pulse) pulse_side(vecs[i].side_lvl);
      end
      for (int t = 0; t < vecs[i].ticks; t++) tick(vecs[i].gap);
      check_out();
    end

    // Reset mid SIDE_Y with a request latched: aborts phase, clears latch.
    pulse_side(1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    push_exp(100, 3'd5, 6'd1, R, R);
    check_out();
    push_exp(101, 3'd5, 6'd1, R, R);
    idle(30);                       // no ticks: nothing moves
    check_out();
    push_exp(102, 3'd0, 6'd19, G, R);
    tick(2); tick(2);
    check_out();
    push_exp(103, 3'd0, 6'd0, G, R);
    for (int t = 0; t < 21; t++) tick(2);
    check_out();

    // Full cycle with back-to-back ticks, then with 50-clk spacing.
    side_req = 1'b1;
    idle(1);
    run_cycle(200, 0);
    side_req = 1'b0;
    idle(1);
    push_exp(300, 3'd0, 6'd19, G, R);
    for (int t = 0; t < 34; t++) tick(2);
    check_out();
    push_exp(301, 3'd0, 6'd0, G, R);
    for (int t = 0; t < 20; t++) tick(2);
    check_out();
    side_req = 1'b1;
    idle(1);
    run_cycle(400, 49);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
